// File: rtl/genfor_cnt_bank.sv
// Parametrised bank of saturating per-channel event counters with indexed clear
// and a valid/ready read port backed by a one-entry response buffer.
module genfor_cnt_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int RD_CLR = 0,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] inc,
  input  logic              clr_vld,
  input  logic [IDX_W-1:0]  clr_idx,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_rsp_vld,
  input  logic              rd_rsp_rdy,
  output logic [CNT_W-1:0]  rd_rsp_data,
  output logic              rd_rsp_sat,
  output logic              any_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                     rd_accept;
  logic [NUM_CH*CNT_W-1:0]  cnt_flat;
  logic [NUM_CH-1:0]        sat_vec;
  logic [CNT_W-1:0]         rd_cnt_sel;
  logic                     rd_sat_sel;

  assign rd_req_rdy = !rd_rsp_vld || rd_rsp_rdy;
  assign rd_accept  = rd_req_vld && rd_req_rdy;
  assign any_sat    = |sat_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat;
    logic             clr_hit;

    // Out-of-range indices never equal any generated i, so they touch nothing.
    assign clr_hit = (clr_vld && (clr_idx == IDX_W'(i))) ||
                     ((RD_CLR != 0) && rd_accept && (rd_idx == IDX_W'(i)));

    // Clear wins first, then a same-cycle increment lands on the zeroed value.
    always_comb begin
      cnt_nxt = cnt;
      if (clr_hit) begin
        cnt_nxt = inc[i] ? CNT_W'(1) : '0;
      end else if (inc[i] && (cnt != CNT_MAX)) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        sat <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        sat <= (cnt_nxt == CNT_MAX);
      end
    end

    assign cnt_flat[i*CNT_W +: CNT_W] = cnt;
    assign sat_vec[i]                 = sat;
  end

  always_comb begin
    rd_cnt_sel = '0;
    rd_sat_sel = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (rd_idx == IDX_W'(j)) begin
        rd_cnt_sel = cnt_flat[j*CNT_W +: CNT_W];
        rd_sat_sel = sat_vec[j];
      end
    end
  end

  // Response buffer: load on accept, drain on ready; data only moves on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rsp_vld  <= 1'b0;
      rd_rsp_data <= '0;
      rd_rsp_sat  <= 1'b0;
    end else if (rd_accept) begin
      rd_rsp_vld  <= 1'b1;
      rd_rsp_data <= rd_cnt_sel;
      rd_rsp_sat  <= rd_sat_sel;
    end else if (rd_rsp_rdy) begin
      rd_rsp_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_genfor_cnt_bank.sv
// Directed self-checking bench: a default-parameter bank plus a 5-channel,
// 4-bit, read-clear bank, each exercised with hand-computed expectations.
module tb_genfor_cnt_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] a_inc = '0;
  logic       a_clr_vld = 1'b0;
  logic [1:0] a_clr_idx = '0;
  logic       a_rd_vld = 1'b0;
  logic       a_rdy;
  logic [1:0] a_rd_idx = '0;
  logic       a_rsp_vld;
  logic       a_rsp_rdy = 1'b1;
  logic [7:0] a_data;
  logic       a_sat;
  logic       a_any;

  logic [4:0] b_inc = '0;
  logic       b_clr_vld = 1'b0;
  logic [2:0] b_clr_idx = '0;
  logic       b_rd_vld = 1'b0;
  logic       b_rdy;
  logic [2:0] b_rd_idx = '0;
  logic       b_rsp_vld;
  logic       b_rsp_rdy = 1'b1;
  logic [3:0] b_data;
  logic       b_sat;
  logic       b_any;

  genfor_cnt_bank #(.NUM_CH(4), .CNT_W(8), .RD_CLR(0)) dut_a (
    .clk(clk), .rst(rst), .inc(a_inc), .clr_vld(a_clr_vld), .clr_idx(a_clr_idx),
    .rd_req_vld(a_rd_vld), .rd_req_rdy(a_rdy), .rd_idx(a_rd_idx),
    .rd_rsp_vld(a_rsp_vld), .rd_rsp_rdy(a_rsp_rdy), .rd_rsp_data(a_data),
    .rd_rsp_sat(a_sat), .any_sat(a_any)
  );

  genfor_cnt_bank #(.NUM_CH(5), .CNT_W(4), .RD_CLR(1)) dut_b (
    .clk(clk), .rst(rst), .inc(b_inc), .clr_vld(b_clr_vld), .clr_idx(b_clr_idx),
    .rd_req_vld(b_rd_vld), .rd_req_rdy(b_rdy), .rd_idx(b_rd_idx),
    .rd_rsp_vld(b_rsp_vld), .rd_rsp_rdy(b_rsp_rdy), .rd_rsp_data(b_data),
    .rd_rsp_sat(b_sat), .any_sat(b_any)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulusA(input logic [3:0] inc, input logic clr, input logic [1:0] cidx,
                                input logic rv, input logic [1:0] ridx, input logic rr);
    a_inc = inc; a_clr_vld = clr; a_clr_idx = cidx;
    a_rd_vld = rv; a_rd_idx = ridx; a_rsp_rdy = rr;
    tick();
  endtask

  task automatic applyStimulusB(input logic [4:0] inc, input logic clr, input logic [2:0] cidx,
                                input logic rv, input logic [2:0] ridx, input logic rr);
    b_inc = inc; b_clr_vld = clr; b_clr_idx = cidx;
    b_rd_vld = rv; b_rd_idx = ridx; b_rsp_rdy = rr;
    tick();
  endtask

  task automatic readA(input logic [1:0] idx, input logic [7:0] exp, input logic exp_sat, input string tag);
    applyStimulusA(4'b0000, 1'b0, 2'd0, 1'b1, idx, 1'b1);
    checkOutput({tag, "_vld"}, a_rsp_vld, 1);
    checkOutput({tag, "_data"}, a_data, exp);
    checkOutput({tag, "_sat"}, a_sat, exp_sat);
  endtask

  task automatic readB(input logic [2:0] idx, input logic [3:0] exp, input logic exp_sat, input string tag);
    applyStimulusB(5'b00000, 1'b0, 3'd0, 1'b1, idx, 1'b1);
    checkOutput({tag, "_vld"}, b_rsp_vld, 1);
    checkOutput({tag, "_data"}, b_data, exp);
    checkOutput({tag, "_sat"}, b_sat, exp_sat);
  endtask

  initial begin
    // Reset with a pending read request on both banks; reset must win.
    rst = 1'b1;
    a_rd_vld = 1'b1; b_rd_vld = 1'b1; a_inc = 4'hF; b_inc = 5'h1F;
    tick();
    tick();
    a_rd_vld = 1'b0; b_rd_vld = 1'b0; a_inc = '0; b_inc = '0;
    rst = 1'b0;
    checkOutput("rst_a_vld", a_rsp_vld, 0);
    checkOutput("rst_a_data", a_data, 0);
    checkOutput("rst_a_any", a_any, 0);
    checkOutput("rst_a_rdy", a_rdy, 1);
    checkOutput("rst_b_vld", b_rsp_vld, 0);
    checkOutput("rst_b_any", b_any, 0);

    // Count: five increments on channel 2, others stay zero.
    for (int k = 0; k < 5; k++) applyStimulusA(4'b0100, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    readA(2'd2, 8'd5, 1'b0, "cnt_ch2");
    readA(2'd0, 8'd0, 1'b0, "cnt_ch0");
    readA(2'd1, 8'd0, 1'b0, "cnt_ch1");
    readA(2'd3, 8'd0, 1'b0, "cnt_ch3");
    applyStimulusA(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    checkOutput("drain_vld", a_rsp_vld, 0);

    // Clear/increment collision on channel 1 at 9, plain clear of channel 2.
    for (int k = 0; k < 9; k++) applyStimulusA(4'b0010, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    readA(2'd1, 8'd9, 1'b0, "pre_coll");
    applyStimulusA(4'b0010, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1);
    readA(2'd1, 8'd1, 1'b0, "coll_ch1");
    applyStimulusA(4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1);
    readA(2'd2, 8'd0, 1'b0, "clr_ch2");

    // Read captures pre-update value: accept with inc on the same channel.
    for (int k = 0; k < 3; k++) applyStimulusA(4'b1000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    applyStimulusA(4'b1000, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    checkOutput("bp_first_data", a_data, 3);
    checkOutput("bp_first_vld", a_rsp_vld, 1);
    checkOutput("bp_rdy_low", a_rdy, 0);

    // Backpressure: stalled response holds while counter 3 keeps moving.
    for (int k = 0; k < 3; k++) begin
      applyStimulusA(4'b1000, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
      checkOutput($sformatf("bp_hold_data_%0d", k), a_data, 3);
      checkOutput($sformatf("bp_hold_vld_%0d", k), a_rsp_vld, 1);
      checkOutput($sformatf("bp_hold_rdy_%0d", k), a_rdy, 0);
    end
    a_inc = '0; a_rd_idx = 2'd1; a_rsp_rdy = 1'b1;
    #1;
    checkOutput("bp_rdy_comb", a_rdy, 1);
    tick();
    checkOutput("bp_swap_vld", a_rsp_vld, 1);
    checkOutput("bp_swap_data", a_data, 1);
    readA(2'd3, 8'd7, 1'b0, "bp_ch3_after");

    // Saturation on a 4-bit counter: stop at 15, any_sat from the 15th edge.
    for (int k = 1; k <= 20; k++) begin
      applyStimulusB(5'b00001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      checkOutput($sformatf("sat_any_%0d", k), b_any, (k >= 15) ? 1 : 0);
    end
    readB(3'd0, 4'd15, 1'b1, "sat_read");
    checkOutput("sat_rdclr_any", b_any, 0);
    for (int k = 0; k < 15; k++) applyStimulusB(5'b00001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    checkOutput("resat_any", b_any, 1);
    applyStimulusB(5'b00000, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1);
    checkOutput("sat_clr_any", b_any, 0);

    // Read-clear: channel 3 at 7, read with same-cycle inc, then without.
    for (int k = 0; k < 7; k++) applyStimulusB(5'b01000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    applyStimulusB(5'b01000, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1);
    checkOutput("rc_first_data", b_data, 7);
    readB(3'd3, 4'd1, 1'b0, "rc_second");
    readB(3'd3, 4'd0, 1'b0, "rc_third");

    // Read-clear, clr_vld and inc all on channel 4 in one cycle.
    for (int k = 0; k < 2; k++) applyStimulusB(5'b10000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    applyStimulusB(5'b10000, 1'b1, 3'd4, 1'b1, 3'd4, 1'b1);
    checkOutput("tri_data", b_data, 2);
    readB(3'd4, 4'd1, 1'b0, "tri_after");

    // Out-of-range read and clear on the 5-channel bank.
    readB(3'd6, 4'd0, 1'b0, "oor_read");
    for (int k = 0; k < 3; k++) applyStimulusB(5'b00010, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    applyStimulusB(5'b00000, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1);
    readB(3'd1, 4'd3, 1'b0, "oor_clr_ch1");

    // Reset while a response is stalled drops it.
    for (int k = 0; k < 2; k++) applyStimulusB(5'b00100, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    applyStimulusB(5'b00000, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0);
    checkOutput("mid_pre_vld", b_rsp_vld, 1);
    checkOutput("mid_pre_data", b_data, 2);
    rst = 1'b1;
    applyStimulusB(5'b00000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_vld", b_rsp_vld, 0);
    checkOutput("mid_rst_data", b_data, 0);
    checkOutput("mid_rst_rdy", b_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/genfor_cnt_bank.md
# genfor_cnt_bank

Parametrised bank of `NUM_CH` per-channel saturating event counters, built from a generate-for loop of identical channel slices. Read and clear access to the slices is indexed. Successor to the fixed-size generate-array channel blocks: width, channel count and read-clear mode are generalised, and a valid/ready read port with a one-entry response buffer is added. It sits beside datapath blocks as a statistics/event-count unit.

## Interface
- `NUM_CH`, 4: number of channel slices, 1..64; need not be a power of two.
- `CNT_W`, 8: counter width per channel, 2..32.
- `RD_CLR`, 0: 1 = an accepted read also clears the addressed counter.
- `IDX_W`, `$clog2(NUM_CH)` (minimum 1): index width, derived.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inc`  in  NUM_CH  per-channel increment strobe; bit i increments channel i.
- `clr_vld`  in  1  clear request, single-cycle, always accepted.
- `clr_idx`  in  IDX_W  channel to clear.
- `rd_req_vld`  in  1  read request valid.
- `rd_req_rdy`  out  1  read request ready.
- `rd_idx`  in  IDX_W  channel to read.
- `rd_rsp_vld`  out  1  response valid.
- `rd_rsp_rdy`  in  1  response ready.
- `rd_rsp_data`  out  CNT_W  captured counter value.
- `rd_rsp_sat`  out  1  captured saturation flag.
- `any_sat`  out  1  OR of all channel saturation flags.

## Operation
- Each generated slice i holds `cnt[i]` (CNT_W bits) and `sat[i]`.
  - `sat[i]` is 1 when `cnt[i] == 2^CNT_W-1`.
  - `sat[i]` is a registered copy and updates on the same edge as `cnt[i]`.
- Increment: `inc[i]` high and `cnt[i]` below max gives `cnt[i]+1`. At max the counter holds; no wrap, ever.
- Clear: `clr_vld` and `clr_idx == i` give `cnt[i] = 0`.
- Simultaneous clear and `inc[i]` on the same channel: `cnt[i] = 1`. Clear applies first, then the increment.
- Read accept: `rd_req_vld && rd_req_rdy`.
  - `rd_req_rdy = !rd_rsp_vld || rd_rsp_rdy`. Combinational; it depends on `rd_rsp_rdy`, never on `rd_req_vld`.
  - On accept, `rd_rsp_data`/`rd_rsp_sat` capture the pre-update `cnt`/`sat` of `rd_idx`. Same-cycle increments are not included.
- Response buffer is one entry.
  - `rd_rsp_vld` sets on accept.
  - It clears on `rd_rsp_rdy` when no new accept occurs in that cycle.
  - Accept together with drain keeps `rd_rsp_vld` at 1 and loads the new data.
- `RD_CLR=1`: an accepted read clears the addressed counter, in the same way as a clear.
  - Read-clear, `clr_vld` and `inc` may all target one channel in the same cycle: the result is `cnt = inc ? 1 : 0`.
- Out-of-range index (`>= NUM_CH`):
  - A read is accepted and returns data 0, sat 0.
  - A clear has no effect.
- `rd_rsp_data`/`rd_rsp_sat` hold stable while `rd_rsp_vld && !rd_rsp_rdy`.
- `any_sat` is combinational OR of the registered `sat` flags.

## Timing
- Reset, sync, wins over every other input on that edge:
  - all `cnt` = 0 and all `sat` = 0.
  - `rd_rsp_vld` = 0, `rd_rsp_data` = 0, `rd_rsp_sat` = 0.
  - `any_sat` = 0.
  - `rd_req_rdy` = 1 from the first cycle after reset.
- Reset mid-transaction drops any pending response. It is not replayed.
- Increment/clear latency: 1 clock. The new value is visible to a read accepted on the following cycle.
- Read latency: accept at edge N gives `rd_rsp_vld` = 1 after edge N.
- Throughput: 1 read/clock while `rd_rsp_rdy` is held high.
- `any_sat` rises in the cycle after the edge where the last increment reaches max.

## Test plan
- **Reset and count:** reset, then pulse `inc[2]` for 5 cycles and read idx 2. Expect data 5, sat 0; other channels read 0.
- **Saturation:** `CNT_W=4`, hold `inc[0]` high for 20 cycles.
  - `cnt[0]` stops at 15, with no wrap.
  - `sat`/`any_sat` = 1 from the cycle after the 15th increment.
  - Clearing idx 0 drops `any_sat` to 0 the next cycle.
- **Clear/increment collision:** channel 1 at 9; in one cycle assert `clr_vld` with `clr_idx=1` and `inc[1]`. Next read of idx 1 returns 1.
- **Backpressure:**
  - Hold `rd_rsp_rdy=0` after one accept; `rd_req_rdy` = 0 and the response data stays stable for 3 cycles.
  - Raise `rd_rsp_rdy` together with a new request; the new data appears the next cycle and `rd_rsp_vld` stays 1.
- **Read-clear mode:** `RD_CLR=1`, channel 3 at 7.
  - Read idx 3 with `inc[3]` in the same cycle: response 7; the following read returns 1.
  - With no increment in that cycle, the following read returns 0.
- **Odd channel count:** `NUM_CH=5`.
  - Reading idx 6 returns 0/0 with `rd_rsp_vld` asserted.
  - A clear of idx 7 leaves all counters unchanged.
  - Reset asserted while `rd_rsp_vld=1` gives `rd_rsp_vld=0` the next cycle.
